// File: rtl/usb_dac_sample_buffer.sv
// FX3 slave-FIFO capture into a circular buffer, played out to the DAC at a programmable rate.
// Build option: define USB_DAC_OFFSET_BIN_EN to convert two's-complement words to offset binary.
module usb_dac_sample_buffer #(
    parameter int DW           = 16,
    parameter int AW           = 10,
    parameter int RD_LAT       = 2,
    parameter int PRIME_LVL    = 512,
    parameter int AFULL_MARGIN = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          SLRD,
    input  logic [DW-1:0] usb_data,
    input  logic          enable,
    input  logic [15:0]   rate_div,
    input  logic          clr_err,
    output logic [DW-1:0] dac_data,
    output logic          dac_valid,
    output logic [AW:0]   fifo_level,
    output logic          almost_full,
    output logic          overflow,
    output logic          underflow
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PRIME_TH = (AW+1)'(PRIME_LVL);
    localparam logic [AW:0]   AFULL_TH = (AW+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN, STARVE} state_t;

    function automatic logic [DW-1:0] dac_xform(input logic signed [DW-1:0] word);
`ifdef USB_DAC_OFFSET_BIN_EN
        return {~word[DW-1], word[DW-2:0]};
`else
        return word;
`endif
    endfunction

    logic [RD_LAT-1:0] cap_vld_p;
    logic [DW-1:0]     mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       level;
    logic [AW:0]       level_nxt;
    logic [15:0]       tick_cnt;
    state_t            state;

    logic cap_vld;
    logic full;
    logic empty;
    logic tick;
    logic pop;
    logic push;
    logic drop;

    assign cap_vld    = cap_vld_p[RD_LAT-1];
    assign full       = (level == FULL_LVL);
    assign empty      = (level == '0);
    assign tick       = enable && (state == RUN) && (tick_cnt == 16'd0);
    assign pop        = tick && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the word.
    assign push       = cap_vld && (!full || pop);
    assign drop       = cap_vld && full && !pop;
    assign fifo_level = level;

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Stage p0..p(RD_LAT-1): read strobe delayed to line up with the FX3 data bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_p <= '0;
        end else begin
            cap_vld_p[0] <= ~SLRD;
            for (int i = 1; i < RD_LAT; i++) begin
                cap_vld_p[i] <= cap_vld_p[i-1];
            end
        end
    end

    // FIFO storage: written on the edge the delayed strobe emerges
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= usb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            level       <= level_nxt;
            almost_full <= (level_nxt >= AFULL_TH);
        end
    end

    // Sticky status: a set event in the same cycle as clr_err keeps the flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (tick && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // Playback stage: tick counter and DAC output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= 16'd0;
            dac_data  <= MIDSCALE;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                dac_data <= MIDSCALE;
            end else begin
                case (state)
                    IDLE: begin
                        dac_data <= MIDSCALE;
                        state    <= PRIME;
                    end
                    PRIME: begin
                        if (level >= PRIME_TH) begin
                            state    <= RUN;
                            tick_cnt <= rate_div;
                        end
                    end
                    RUN: begin
                        if (tick_cnt == 16'd0) begin
                            tick_cnt <= rate_div;
                            if (!empty) begin
                                dac_data  <= dac_xform(mem[rptr[AW-1:0]]);
                                dac_valid <= 1'b1;
                            end else begin
                                state <= STARVE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt - 16'd1;
                        end
                    end
                    STARVE: begin
                        if (level >= PRIME_TH) begin
                            state    <= RUN;
                            tick_cnt <= rate_div;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/usb_dac_sample_buffer.md
Name: usb_dac_sample_buffer

Overview:
- Sits directly downstream of the FX3 slave-FIFO read controller.
- Captures each word the FX3 drives on its data bus after the controller pulses SLRD low, and accounts for the FX3 read latency.
- Buffers captured words in an internal circular FIFO, then plays them out to the DA converter at a programmable sample rate.
- Reports fill level, almost-full, and sticky overflow/underflow status.

Parameters:
- DW, 16: FX3 data bus width and DAC sample width.
- AW, 10: FIFO address width; depth is 2^AW words.
- RD_LAT, 2: clk cycles from SLRD sampled low until the matching word is valid on usb_data. Legal range 1..4.
- PRIME_LVL, 512: fill level required before playback starts or resumes.
- AFULL_MARGIN, 256: almost_full asserts when level >= 2^AW - AFULL_MARGIN.

Ports:
- clk  input  1  system clock (same clock as the read controller).
- rst_n  input  1  reset, asynchronous assert, active-low.
- SLRD  input  1  active-low read strobe from the read controller.
- usb_data  input  DW  FX3 data bus.
- enable  input  1  playback enable.
- rate_div  input  16  output sample period minus 1, in clk cycles.
- clr_err  input  1  clears the sticky error flags.
- dac_data  output  DW  sample to the DAC, registered.
- dac_valid  output  1  one-cycle pulse each time dac_data updates from the FIFO.
- fifo_level  output  AW+1  current word count, 0..2^AW.
- almost_full  output  1  level >= 2^AW - AFULL_MARGIN.
- overflow  output  1  sticky: a captured word was dropped.
- underflow  output  1  sticky: a sample tick found the FIFO empty.

Behaviour:
- Reset (async, rst_n low):
  - dac_data = 1<<(DW-1) (midscale); dac_valid, overflow and underflow = 0; fifo_level = 0.
  - Pointers = 0; capture pipeline cleared; state = IDLE; tick counter = 0.
- Capture:
  - An RD_LAT-deep shift register carries ~SLRD.
  - When the last stage is 1, usb_data is written into the FIFO on that edge. Write latency = RD_LAT cycles after SLRD is sampled low.
  - Back-to-back SLRD-low cycles capture one word per cycle.
- FIFO:
  - Read and write pointers are AW+1 bits and wrap naturally.
  - Level = wptr - rptr. Full when level = 2^AW; empty when level = 0.
  - Write while full: word dropped, pointers unchanged, overflow set.
  - Push and pop in the same cycle: both execute, level unchanged. Not permitted when full with no pop.
  - No bypass: a pop in the same cycle as a push into an empty FIFO sees empty.
- Playback FSM:
  - IDLE: dac_data held at midscale. enable=1 -> PRIME.
  - PRIME: wait until level >= PRIME_LVL, then -> RUN and load tick counter with rate_div.
  - RUN: counter decrements each cycle. At 0 (tick) the counter reloads from rate_div, sampled at reload.
    - Tick with level > 0: pop a word, dac_data = word (after optional transform), dac_valid = 1 for one cycle. Samples are spaced rate_div+1 cycles; rate_div = 0 gives one sample per cycle.
    - Tick with level = 0: underflow set, dac_data holds its last value, -> STARVE.
  - STARVE: level >= PRIME_LVL -> RUN with counter reloaded.
  - enable=0 in any state -> IDLE next edge, dac_data = midscale. FIFO contents kept; capture continues.
- Status:
  - clr_err clears overflow and underflow. A set event in the same cycle as clr_err wins (flag stays 1).
  - almost_full and fifo_level are registered and reflect post-edge state.
- Reset mid-transfer: all state is lost, and words still in the capture pipeline are discarded.

Optional Feature:
- Macro: USB_DAC_OFFSET_BIN_EN.
- Defined: FIFO words are treated as two's complement. dac_data = word with MSB inverted (offset binary).
- Undefined: words pass through unchanged.
- The idle/reset value of dac_data is 1<<(DW-1) in both builds.

Test Plan:
- RD_LAT=2, SLRD low 1 cycle at cycle 10 with usb_data=0x1234 at cycle 12 -> fifo_level becomes 1 after edge 12; word 0x1234 stored. A value of 0xFFFF driven at cycle 11 must not be captured.
- Fill 1024 words, then one more SLRD pulse -> fifo_level stays 1024, overflow=1. clr_err pulse -> overflow=0. almost_full asserts from level 768.
- enable=1, rate_div=3, 600 words loaded -> PRIME exits, dac_valid pulses every 4 cycles, dac_data follows write order exactly.
- Stop capture during RUN with rate_div=0 -> after the last word, the next tick sets underflow, dac_data holds the last word, no dac_valid. Refill to 512 -> playback resumes.
- enable dropped mid-RUN -> next cycle dac_data=0x8000, state IDLE, fifo_level unchanged. Re-enable resumes only after the PRIME condition is met.
- Assert rst_n low asynchronously mid-capture -> all outputs return to reset values immediately, before the next clk edge.
